// File: rtl/slot_arb_pkg.sv
// Shared types and widths for the slot data arbiter.
package slot_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LISTEN,
    DRIVE
  } slot_arb_state_t;

  localparam int unsigned SETTLE_CNT_W = $clog2(16);
  localparam int unsigned COLL_CNT_W   = 16;

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-wins one-hot priority encoder with any/multi-hot flags.
module prio_onehot #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic             any_o,
  output logic             multi_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (req_i[k] && !found) begin
        onehot_o[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o   = |req_i;
  assign multi_o = |(req_i & ~onehot_o);

endmodule

// File: rtl/slot_data_arbiter.sv
// Per-bus-cycle fixed-priority arbiter for the shared Apple II data-out path and IRQ.
// Optional SLOT_ARB_COLLISION_COUNT_EN adds a saturating collision_count_o.
module slot_data_arbiter
  import slot_arb_pkg::*;
#(
  parameter int unsigned NUM_SOURCES   = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk_logic,
  input  logic                     reset,
  input  logic                     phi1_posedge_i,
  input  logic                     phi1_negedge_i,
  input  logic [NUM_SOURCES-1:0]   rd_en_i,
  input  logic [8*NUM_SOURCES-1:0] data_i,
  input  logic [NUM_SOURCES-1:0]   irq_n_i,
  input  logic [NUM_SOURCES-1:0]   irq_mask_i,
`ifdef SLOT_ARB_COLLISION_COUNT_EN
  output logic [COLL_CNT_W-1:0]    collision_count_o,
`endif
  output logic                     data_out_en_o,
  output logic [7:0]               data_out_o,
  output logic [NUM_SOURCES-1:0]   grant_o,
  output logic                     collision_o,
  output logic                     irq_n_o
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES);

  slot_arb_state_t          state_q, state_d;
  logic [SETTLE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SOURCES-1:0]   grant_q, grant_d;
  logic                     en_q, en_d;
  logic [7:0]               data_q, data_d;
  logic                     coll_q, coll_d;
  logic                     irq_q;

  logic [NUM_SOURCES-1:0]   win_onehot, sel_src;
  logic                     req_any, req_multi, arb;
  logic [7:0]               sel_byte;

  prio_onehot #(.WIDTH(NUM_SOURCES)) u_prio (
    .req_i    (rd_en_i),
    .onehot_o (win_onehot),
    .any_o    (req_any),
    .multi_o  (req_multi)
  );

  // In DRIVE the locked grant selects the byte; otherwise the fresh winner does.
  assign sel_src = (state_q == DRIVE) ? grant_q : win_onehot;

  always_comb begin
    sel_byte = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      if (sel_src[k]) sel_byte = sel_byte | data_i[8*k +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    en_d    = en_q;
    data_d  = data_q;
    coll_d  = 1'b0;
    arb     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (phi1_negedge_i) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        if (cnt_q <= SETTLE_CNT_W'(1)) begin
          arb     = 1'b1;
          state_d = LISTEN;
        end
      end
      LISTEN: arb = 1'b1;
      DRIVE: begin
        if ((rd_en_i & grant_q) == '0) begin
          grant_d = '0;
          en_d    = 1'b0;
          state_d = LISTEN;
        end else begin
          data_d = sel_byte;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb && req_any) begin
      state_d = DRIVE;
      grant_d = win_onehot;
      en_d    = 1'b1;
      data_d  = sel_byte;
      coll_d  = req_multi;
    end

    // Cycle end dominates a coincident phi0 rise; data_out holds its last value.
    if (phi1_posedge_i) begin
      state_d = IDLE;
      grant_d = '0;
      en_d    = 1'b0;
      data_d  = data_q;
      coll_d  = 1'b0;
    end else if (phi1_negedge_i && state_q != IDLE) begin
      state_d = SETTLE;
      cnt_d   = SETTLE_LOAD;
      grant_d = '0;
      en_d    = 1'b0;
      data_d  = data_q;
      coll_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      coll_q  <= 1'b0;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      data_q  <= data_d;
      coll_q  <= coll_d;
      irq_q   <= &(irq_n_i | irq_mask_i);
    end
  end

`ifdef SLOT_ARB_COLLISION_COUNT_EN
  logic [COLL_CNT_W-1:0] coll_cnt_q;

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      coll_cnt_q <= '0;
    end else if (coll_q && coll_cnt_q != '1) begin
      coll_cnt_q <= coll_cnt_q + 1'b1;
    end
  end

  assign collision_count_o = coll_cnt_q;
`endif

  assign data_out_en_o = en_q;
  assign data_out_o    = data_q;
  assign grant_o       = grant_q;
  assign collision_o   = coll_q;
  assign irq_n_o       = irq_q;

endmodule

// File: tb/tb_slot_data_arbiter.sv
// Directed vector table plus reset/latency sequences for slot_data_arbiter.
module tb_slot_data_arbiter;

  typedef struct {
    logic        p1p;
    logic        p1n;
    logic [2:0]  rd;
    logic [23:0] data;
    logic [2:0]  irqn;
    logic [2:0]  mask;
    logic        e_en;
    logic [2:0]  e_gnt;
    logic [7:0]  e_data;
    logic        e_coll;
    logic        e_irq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        p1p, p1n;
  logic [2:0]  rd_en, irq_n, irq_mask;
  logic [23:0] data;
  logic        en_o, coll_o, irq_o;
  logic [7:0]  data_o;
  logic [2:0]  gnt_o;
`ifdef SLOT_ARB_COLLISION_COUNT_EN
  logic [15:0] ccount_o;
`endif

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  slot_data_arbiter #(.NUM_SOURCES(3), .SETTLE_CYCLES(4)) dut (
    .clk_logic      (clk),
    .reset          (rst),
    .phi1_posedge_i (p1p),
    .phi1_negedge_i (p1n),
    .rd_en_i        (rd_en),
    .data_i         (data),
    .irq_n_i        (irq_n),
    .irq_mask_i     (irq_mask),
`ifdef SLOT_ARB_COLLISION_COUNT_EN
    .collision_count_o (ccount_o),
`endif
    .data_out_en_o  (en_o),
    .data_out_o     (data_o),
    .grant_o        (gnt_o),
    .collision_o    (coll_o),
    .irq_n_o        (irq_o)
  );

  task automatic add(input logic p, input logic n, input logic [2:0] r, input logic [23:0] d,
                     input logic [2:0] iq, input logic [2:0] m, input logic ee,
                     input logic [2:0] eg, input logic [7:0] ed, input logic ec, input logic ei);
    vec_t v;
    v.p1p = p; v.p1n = n; v.rd = r; v.data = d; v.irqn = iq; v.mask = m;
    v.e_en = ee; v.e_gnt = eg; v.e_data = ed; v.e_coll = ec; v.e_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic addn(input int cnt, input logic [2:0] r, input logic [23:0] d,
                      input logic ee, input logic [2:0] eg, input logic [7:0] ed);
    for (int i = 0; i < cnt; i++) add(0, 0, r, d, 3'b111, 3'b000, ee, eg, ed, 0, 1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p1p = 0; p1n = 0; rd_en = 3'b000; data = 24'h0; irq_n = 3'b111; irq_mask = 3'b000;
  endtask

  initial begin
    int lat;
    logic seen;

    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset_state", {en_o, gnt_o, data_o, coll_o, irq_o}, {1'b0, 3'b000, 8'h00, 1'b0, 1'b1});
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single request from source 2.
    add(0, 1, 3'b100, 24'hA50000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 1);
    addn(3, 3'b100, 24'hA50000, 0, 3'b000, 8'h00);
    add(0, 0, 3'b100, 24'hA50000, 3'b111, 3'b000, 1, 3'b100, 8'hA5, 0, 1);
    add(0, 0, 3'b100, 24'h5A0000, 3'b111, 3'b000, 1, 3'b100, 8'h5A, 0, 1);
    add(1, 0, 3'b100, 24'h5A0000, 3'b111, 3'b000, 0, 3'b000, 8'h5A, 0, 1);
    // Collision at settle end, then source 0 drops and source 1 takes over.
    add(0, 1, 3'b000, 24'h002211, 3'b111, 3'b000, 0, 3'b000, 8'h5A, 0, 1);
    addn(3, 3'b000, 24'h002211, 0, 3'b000, 8'h5A);
    add(0, 0, 3'b011, 24'h002211, 3'b111, 3'b000, 1, 3'b001, 8'h11, 1, 1);
    add(0, 0, 3'b011, 24'h002211, 3'b111, 3'b000, 1, 3'b001, 8'h11, 0, 1);
    add(0, 0, 3'b010, 24'h002211, 3'b111, 3'b000, 0, 3'b000, 8'h11, 0, 1);
    add(0, 0, 3'b010, 24'h002211, 3'b111, 3'b000, 1, 3'b010, 8'h22, 0, 1);
    add(1, 0, 3'b010, 24'h002211, 3'b111, 3'b000, 0, 3'b000, 8'h22, 0, 1);
    // No request at settle end; late request in LISTEN.
    add(0, 1, 3'b000, 24'h003C00, 3'b111, 3'b000, 0, 3'b000, 8'h22, 0, 1);
    addn(6, 3'b000, 24'h003C00, 0, 3'b000, 8'h22);
    add(0, 0, 3'b010, 24'h003C00, 3'b111, 3'b000, 1, 3'b010, 8'h3C, 0, 1);
    add(1, 0, 3'b010, 24'h003C00, 3'b111, 3'b000, 0, 3'b000, 8'h3C, 0, 1);
    // Locked grant: higher priority arriving late does not pre-empt.
    add(0, 1, 3'b100, 24'h770099, 3'b111, 3'b000, 0, 3'b000, 8'h3C, 0, 1);
    addn(3, 3'b100, 24'h770099, 0, 3'b000, 8'h3C);
    add(0, 0, 3'b100, 24'h770099, 3'b111, 3'b000, 1, 3'b100, 8'h77, 0, 1);
    addn(2, 3'b101, 24'h770099, 1, 3'b100, 8'h77);
    add(1, 0, 3'b101, 24'h770099, 3'b111, 3'b000, 0, 3'b000, 8'h77, 0, 1);
    addn(1, 3'b000, 24'h770099, 0, 3'b000, 8'h77);
    // Glitch: both pulses together stay in IDLE.
    add(1, 1, 3'b001, 24'h000042, 3'b111, 3'b000, 0, 3'b000, 8'h77, 0, 1);
    addn(6, 3'b001, 24'h000042, 0, 3'b000, 8'h77);
    // Missed edge restarts settle.
    add(0, 1, 3'b001, 24'h000042, 3'b111, 3'b000, 0, 3'b000, 8'h77, 0, 1);
    addn(3, 3'b001, 24'h000042, 0, 3'b000, 8'h77);
    add(0, 0, 3'b001, 24'h000042, 3'b111, 3'b000, 1, 3'b001, 8'h42, 0, 1);
    add(0, 1, 3'b001, 24'h000042, 3'b111, 3'b000, 0, 3'b000, 8'h42, 0, 1);
    addn(3, 3'b001, 24'h000042, 0, 3'b000, 8'h42);
    add(0, 0, 3'b001, 24'h000042, 3'b111, 3'b000, 1, 3'b001, 8'h42, 0, 1);
    add(1, 0, 3'b001, 24'h000042, 3'b111, 3'b000, 0, 3'b000, 8'h42, 0, 1);
    // Interrupt masking.
    add(0, 0, 3'b000, 24'h0, 3'b110, 3'b000, 0, 3'b000, 8'h42, 0, 0);
    add(0, 0, 3'b000, 24'h0, 3'b110, 3'b001, 0, 3'b000, 8'h42, 0, 1);
    add(0, 0, 3'b000, 24'h0, 3'b011, 3'b001, 0, 3'b000, 8'h42, 0, 0);
    add(0, 0, 3'b000, 24'h0, 3'b111, 3'b000, 0, 3'b000, 8'h42, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      p1p = vecs[i].p1p; p1n = vecs[i].p1n; rd_en = vecs[i].rd; data = vecs[i].data;
      irq_n = vecs[i].irqn; irq_mask = vecs[i].mask;
      @(posedge clk); #1;
      check($sformatf("row%0d", i), {en_o, gnt_o, data_o, coll_o, irq_o},
            {vecs[i].e_en, vecs[i].e_gnt, vecs[i].e_data, vecs[i].e_coll, vecs[i].e_irq});
    end

`ifdef SLOT_ARB_COLLISION_COUNT_EN
    check("coll_count", ccount_o, 32'd1);
`endif

    // Reach DRIVE and measure first-drive latency.
    @(negedge clk);
    idle_inputs();
    rd_en = 3'b001; data = 24'h0000AB; irq_n = 3'b000;
    p1n = 1'b1;
    @(negedge clk);
    p1n = 1'b0;
    lat = 0;
    for (int c = 2; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (en_o) lat = c;
    end
    check("drive_latency", lat, 5);
    check("drive_data", {gnt_o, data_o}, {3'b001, 8'hAB});

    // Asynchronous reset in the middle of DRIVE.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {en_o, gnt_o, data_o, coll_o, irq_o}, {1'b0, 3'b000, 8'h00, 1'b0, 1'b1});
`ifdef SLOT_ARB_COLLISION_COUNT_EN
    check("coll_count_reset", ccount_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (en_o) seen = 1'b1;
    end
    check("no_drive_after_reset", seen, 1'b0);

    @(negedge clk);
    p1n = 1'b1;
    @(negedge clk);
    p1n = 1'b0;
    lat = 0;
    for (int c = 2; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (en_o) lat = c;
    end
    check("relatency_after_reset", lat, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
